// File: rtl/daq_pkg.sv
// ---------------------------------------------------------------------------
// daq_pkg
// Shared definitions for the DAQ frame builder: FSM state encoding, default
// framing magic bytes and the fixed header/trailer lengths.
// ---------------------------------------------------------------------------
package daq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HEADER   = 3'd1,
        WAIT_SMP = 3'd2,
        SERIAL   = 3'd3,
        TRAILER  = 3'd4
    } daq_state_t;

    localparam logic [7:0] MAGIC_HDR = 8'hA5;
    localparam logic [7:0] MAGIC_TRL = 8'h5A;
    localparam int         HDR_LEN   = 8;
    localparam int         TRL_LEN   = 2;

endpackage

// File: rtl/daq_packetizer.sv
// ---------------------------------------------------------------------------
// daq_packetizer
// Builds one DAQ frame per trigger for the TCP TX FIFO:
//   8-byte header | data_number sample sets (2 bytes per enabled channel,
//   MSB first, channel 0 upward) | 2-byte trailer (magic, overrun count).
//
// Ports
//   clk           system clock
//   sys_rst       synchronous active-high reset
//   trigger_cmd   one-cycle start pulse (ignored while busy)
//   data_number   sample sets per frame, latched at trigger
//   channel_ctrl  channel enable mask, latched at trigger
//   adc_valid     adc_data carries a new sample set
//   adc_data      channel i at [SAMPLE_W*i +: SAMPLE_W]
//   tx_full       downstream almost-full; blocks byte launch
//   tx_data       registered output byte
//   tx_wr         registered byte strobe, one cycle per byte
//   busy          high while a frame is in progress
// ---------------------------------------------------------------------------
module daq_packetizer #(
    parameter int         NUM_CH    = 8,
    parameter int         SAMPLE_W  = 16,
    parameter logic [7:0] MAGIC_HDR = daq_pkg::MAGIC_HDR,
    parameter logic [7:0] MAGIC_TRL = daq_pkg::MAGIC_TRL
) (
    input  logic                       clk,
    input  logic                       sys_rst,
    input  logic                       trigger_cmd,
    input  logic [31:0]                data_number,
    input  logic [NUM_CH-1:0]          channel_ctrl,
    input  logic                       adc_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] adc_data,
    input  logic                       tx_full,
    output logic [7:0]                 tx_data,
    output logic                       tx_wr,
    output logic                       busy
);
    import daq_pkg::*;

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    daq_state_t                 state_q, state_d;
    logic [2:0]                 byte_idx_q, byte_idx_d;    // header/trailer byte index
    logic [31:0]                num_q, num_d;
    logic [31:0]                remaining_q, remaining_d;
    logic [NUM_CH-1:0]          mask_q, mask_d;
    logic [NUM_CH-1:0]          done_q, done_d;            // channels already sent this set
    logic                       lo_q, lo_d;                // 0: next byte is MSB, 1: LSB
    logic [15:0]                frame_cnt_q, frame_cnt_d;
    logic [7:0]                 ovr_cnt_q, ovr_cnt_d;
    logic [7:0]                 ovr_frz_q, ovr_frz_d;      // overrun count frozen for trailer
    logic [7:0]                 tx_data_q, tx_data_d;
    logic                       tx_wr_q, tx_wr_d;
    logic                       busy_q, busy_d;
    logic [NUM_CH*SAMPLE_W-1:0] smp_q;

    // ------------------------------------------------------------------
    // Channel selection
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0]   pend;
    logic [NUM_CH-1:0]   sel_onehot;
    logic [NUM_CH-1:0]   pend_after;
    logic [CH_W-1:0]     ch_sel;
    logic [SAMPLE_W-1:0] cur_smp;
    logic                snap_en;

    assign pend = mask_q & ~done_q;

    // Lowest pending channel wins; scanning downward lets the lowest
    // index overwrite any higher one.
    always_comb begin
        ch_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend[i]) begin
                ch_sel = CH_W'(i);
            end
        end
    end

    assign sel_onehot = NUM_CH'(1) << ch_sel;
    // Channels still owed after the one currently being serialised.
    assign pend_after = pend & ~sel_onehot;
    assign cur_smp    = smp_q[ch_sel*SAMPLE_W +: SAMPLE_W];

    // ------------------------------------------------------------------
    // Header / trailer byte muxes
    // ------------------------------------------------------------------
    logic [7:0] hdr_byte;
    logic [7:0] trl_byte;
    logic [7:0] mask_byte;

    assign mask_byte = 8'(mask_q);

    always_comb begin
        hdr_byte = MAGIC_HDR;
        case (byte_idx_q)
            3'd0:    hdr_byte = MAGIC_HDR;
            3'd1:    hdr_byte = frame_cnt_q[15:8];
            3'd2:    hdr_byte = frame_cnt_q[7:0];
            3'd3:    hdr_byte = mask_byte;
            3'd4:    hdr_byte = num_q[31:24];
            3'd5:    hdr_byte = num_q[23:16];
            3'd6:    hdr_byte = num_q[15:8];
            default: hdr_byte = num_q[7:0];
        endcase
    end

    assign trl_byte = byte_idx_q[0] ? ovr_frz_q : MAGIC_TRL;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        num_d       = num_q;
        remaining_d = remaining_q;
        mask_d      = mask_q;
        done_d      = done_q;
        lo_d        = lo_q;
        frame_cnt_d = frame_cnt_q;
        ovr_cnt_d   = ovr_cnt_q;
        ovr_frz_d   = ovr_frz_q;
        tx_data_d   = tx_data_q;
        tx_wr_d     = 1'b0;
        snap_en     = 1'b0;

        // A sample set arriving while bytes are being pushed out has nowhere
        // to go; it is dropped and only counted.
        if (adc_valid && (state_q == HEADER || state_q == SERIAL || state_q == TRAILER)
                && ovr_cnt_q != 8'hFF) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                // busy_q covers the cycle after the last trailer byte, when
                // the FSM is already back in IDLE but the frame is still
                // reported as busy.
                if (trigger_cmd && !busy_q) begin
                    num_d       = data_number;
                    remaining_d = data_number;
                    mask_d      = channel_ctrl;
                    ovr_cnt_d   = 8'd0;
                    byte_idx_d  = 3'd0;
                    state_d     = HEADER;
                end
            end

            HEADER: begin
                if (!tx_full) begin
                    tx_wr_d    = 1'b1;
                    tx_data_d  = hdr_byte;
                    byte_idx_d = byte_idx_q + 3'd1;
                    if (byte_idx_q == 3'(HDR_LEN - 1)) begin
                        byte_idx_d = 3'd0;
                        if (num_q == 32'd0 || mask_q == '0) begin
                            ovr_frz_d = ovr_cnt_d;
                            state_d   = TRAILER;
                        end else begin
                            state_d   = WAIT_SMP;
                        end
                    end
                end
            end

            WAIT_SMP: begin
                if (adc_valid) begin
                    snap_en = 1'b1;
                    done_d  = '0;
                    lo_d    = 1'b0;
                    state_d = SERIAL;
                end
            end

            SERIAL: begin
                if (!tx_full) begin
                    tx_wr_d = 1'b1;
                    if (!lo_q) begin
                        tx_data_d = cur_smp[15:8];
                        lo_d      = 1'b1;
                    end else begin
                        tx_data_d = cur_smp[7:0];
                        lo_d      = 1'b0;
                        done_d    = done_q | sel_onehot;
                        if (pend_after == '0) begin
                            remaining_d = remaining_q - 32'd1;
                            if (remaining_q == 32'd1) begin
                                ovr_frz_d = ovr_cnt_d;
                                state_d   = TRAILER;
                            end else begin
                                state_d   = WAIT_SMP;
                            end
                        end
                    end
                end
            end

            TRAILER: begin
                if (!tx_full) begin
                    tx_wr_d    = 1'b1;
                    tx_data_d  = trl_byte;
                    byte_idx_d = byte_idx_q + 3'd1;
                    if (byte_idx_q == 3'(TRL_LEN - 1)) begin
                        byte_idx_d  = 3'd0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Hold busy through the cycle carrying the final byte.
        busy_d = (state_d != IDLE) || tx_wr_d;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            byte_idx_q  <= 3'd0;
            num_q       <= 32'd0;
            remaining_q <= 32'd0;
            mask_q      <= '0;
            done_q      <= '0;
            lo_q        <= 1'b0;
            frame_cnt_q <= 16'd0;
            ovr_cnt_q   <= 8'd0;
            ovr_frz_q   <= 8'd0;
            tx_data_q   <= 8'd0;
            tx_wr_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            num_q       <= num_d;
            remaining_q <= remaining_d;
            mask_q      <= mask_d;
            done_q      <= done_d;
            lo_q        <= lo_d;
            frame_cnt_q <= frame_cnt_d;
            ovr_cnt_q   <= ovr_cnt_d;
            ovr_frz_q   <= ovr_frz_d;
            tx_data_q   <= tx_data_d;
            tx_wr_q     <= tx_wr_d;
            busy_q      <= busy_d;
        end
    end

    // Sample snapshot needs no reset: it is only read after being loaded.
    always_ff @(posedge clk) begin
        if (snap_en) begin
            smp_q <= adc_data;
        end
    end

    assign tx_data = tx_data_q;
    assign tx_wr   = tx_wr_q;
    assign busy    = busy_q;

endmodule
